// File: rtl/decodificador_passos_pkg.sv
// decodificador_passos_pkg: shared step widths, FSM states and one-hot decode for the toy step logic
package decodificador_passos_pkg;
  localparam int PASSO_W = 3;
  localparam int N_PASSOS = 8;
  typedef enum logic [1:0] {ESPERA = 2'b00, RODANDO = 2'b01, ERRO = 2'b10} estado_t;
  function automatic logic [N_PASSOS-1:0] decod(input logic [PASSO_W-1:0] p);
    return {{(N_PASSOS-1){1'b0}}, 1'b1} << p;
  endfunction
endpackage

// File: rtl/decodificador_passos_filtro_estavel.sv
// filtro_estavel: synchronises an asynchronous bus and strobes once when a code has been stable long enough
module filtro_estavel #(
  parameter int W = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] cand,
  output logic         estavel
);
  logic [SYNC_STAGES-1:0][W-1:0] sync;
  logic [W-1:0] s;
  logic [CNT_W-1:0] cnt;
  assign s = sync[SYNC_STAGES-1];
  // strobe fires only on the cycle the count reaches its limit, so one stable run yields one strobe
  assign estavel = (s == cand) && (cnt == CNT_W'(STABLE_CYCLES - 2));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cand <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt < CNT_W'(STABLE_CYCLES - 1)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/decodificador_passos.sv
// decodificador_passos: validates the divider's step counter and publishes clean step, one-hot and event pulses
module decodificador_passos
  import decodificador_passos_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic                clock_entrada,
  input  logic                botao,
  input  logic                bit0,
  input  logic                bit1,
  input  logic                bit2,
  output logic [PASSO_W-1:0]  passo,
  output logic [N_PASSOS-1:0] passo_onehot,
  output logic                novo_passo,
  output logic                ciclo_completo,
  output logic                erro,
  output logic [1:0]          estado
);
  estado_t st;
  logic [PASSO_W-1:0] cand;
  logic estavel;
  filtro_estavel #(
    .W(PASSO_W), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)
  ) u_filtro (
    .clk(clock_entrada), .rst(botao), .raw({bit2, bit1, bit0}), .cand(cand), .estavel(estavel)
  );
  assign estado = st;
  always_ff @(posedge clock_entrada or posedge botao)
    if (botao) begin
      st <= ESPERA;
      passo <= '0;
      passo_onehot <= '0;
      novo_passo <= 1'b0;
      ciclo_completo <= 1'b0;
      erro <= 1'b0;
    end else begin
      novo_passo <= 1'b0;
      ciclo_completo <= 1'b0;
      case (st)
        ESPERA:
          if (estavel) begin
            passo <= cand;
            passo_onehot <= decod(cand);
            novo_passo <= 1'b1;
            st <= RODANDO;
          end
        RODANDO:
          if (estavel && cand != passo) begin
            if (cand == passo + 1'b1) begin
              passo <= cand;
              passo_onehot <= decod(cand);
              novo_passo <= 1'b1;
              ciclo_completo <= (passo == PASSO_W'(N_PASSOS - 1));
            end else begin
              erro <= 1'b1;
              st <= ERRO;
            end
          end
        ERRO:
          if (estavel && cand == '0) begin
            passo <= '0;
            passo_onehot <= decod('0);
            novo_passo <= 1'b1;
            st <= RODANDO;
          end
        default: begin
          passo_onehot <= '0;
          st <= ESPERA;
        end
      endcase
    end
endmodule

// File: tb/tb_decodificador_passos.sv
// tb_decodificador_passos: table-driven and randomized checks against a run-length step model
module tb_decodificador_passos;
  logic clk = 1'b0;
  logic botao = 1'b1;
  logic [2:0] raw = 3'd0;
  logic [2:0] passo;
  logic [7:0] passo_onehot;
  logic novo_passo, ciclo_completo, erro;
  logic [1:0] estado;

  always #5 clk = ~clk;

  decodificador_passos dut (
    .clock_entrada(clk), .botao(botao), .bit0(raw[0]), .bit1(raw[1]), .bit2(raw[2]),
    .passo(passo), .passo_onehot(passo_onehot), .novo_passo(novo_passo),
    .ciclo_completo(ciclo_completo), .erro(erro), .estado(estado)
  );

  int checks = 0;
  int fails = 0;

  // model: raw delayed two samples, a code is accepted when seen in 16 consecutive samples
  logic [2:0] h0, h1, last;
  int run;
  int m_st;
  logic [2:0] m_passo;
  logic m_np, m_cc, m_erro;
  int np_cnt, cc_cnt, np_at;

  function automatic void m_reset();
    h0 = 0; h1 = 0; last = 0; run = 1;
    m_st = 0; m_passo = 0; m_np = 0; m_cc = 0; m_erro = 0;
  endfunction

  function automatic void accept(input logic [2:0] c);
    if (m_st == 0) begin
      m_passo = c; m_np = 1; m_st = 1;
    end else if (m_st == 1) begin
      if (c == 3'((m_passo + 1) % 8)) begin
        m_cc = (m_passo == 7); m_passo = c; m_np = 1;
      end else if (c != m_passo) begin
        m_erro = 1; m_st = 2;
      end
    end else if (c == 0) begin
      m_passo = 0; m_np = 1; m_st = 1;
    end
  endfunction

  function automatic void m_edge();
    logic [2:0] s;
    s = h1; h1 = h0; h0 = raw;
    m_np = 0; m_cc = 0;
    if (s == last) begin
      if (run < 1000) run++;
    end else begin
      last = s; run = 1;
    end
    if (run == 16) accept(s);
  endfunction

  function automatic logic [15:0] m_vec();
    logic [7:0] oh;
    oh = (m_st == 0) ? 8'h00 : (8'h01 << m_passo);
    return {m_passo, oh, m_np, m_cc, m_erro, 2'(m_st)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int idx);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("cycle", {passo, passo_onehot, novo_passo, ciclo_completo, erro, estado}, m_vec());
    if (novo_passo) begin
      np_cnt++;
      if (np_at == 0) np_at = idx;
    end
    if (ciclo_completo) cc_cnt++;
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    raw = code;
    np_cnt = 0; cc_cnt = 0; np_at = 0;
    for (int i = 1; i <= n; i++) tick(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    botao = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    botao = 1'b0;
    chk("reset", {passo, passo_onehot, novo_passo, ciclo_completo, erro, estado}, 0);
  endtask

  task automatic async_botao(input string name);
    #2 botao = 1'b1;
    #1 chk(name, {passo, passo_onehot, novo_passo, ciclo_completo, erro, estado}, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    botao = 1'b0;
  endtask

  typedef struct {
    bit rst;
    logic [2:0] code;
    int hold;
    logic [2:0] passo;
    bit erro;
    logic [1:0] estado;
    int np;
    int cc;
    int lat;
  } vec_t;

  initial begin
    vec_t tab[$];
    tab.push_back('{1, 3'd0, 30, 3'd0, 0, 2'd1, 1, 0, 0});
    for (int k = 1; k < 8; k++) tab.push_back('{0, 3'(k), 40, 3'(k), 0, 2'd1, 1, 0, 18});
    tab.push_back('{0, 3'd0, 40, 3'd0, 0, 2'd1, 1, 1, 18});
    tab.push_back('{0, 3'd1, 40, 3'd1, 0, 2'd1, 1, 0, 18});
    tab.push_back('{0, 3'd2, 40, 3'd2, 0, 2'd1, 1, 0, 18});
    tab.push_back('{0, 3'd3, 40, 3'd3, 0, 2'd1, 1, 0, 18});
    tab.push_back('{0, 3'd2, 5, 3'd3, 0, 2'd1, 0, 0, 0});
    tab.push_back('{0, 3'd4, 40, 3'd4, 0, 2'd1, 1, 0, 18});
    tab.push_back('{1, 3'd3, 40, 3'd3, 0, 2'd1, 1, 0, 0});
    tab.push_back('{0, 3'd6, 40, 3'd3, 1, 2'd2, 0, 0, 0});
    tab.push_back('{0, 3'd5, 40, 3'd3, 1, 2'd2, 0, 0, 0});
    tab.push_back('{0, 3'd0, 40, 3'd0, 1, 2'd1, 1, 0, 18});
    m_reset();
    foreach (tab[i]) begin
      if (tab[i].rst) do_reset();
      hold(tab[i].code, tab[i].hold);
      chk($sformatf("vec%0d_passo", i), passo, tab[i].passo);
      chk($sformatf("vec%0d_onehot", i), passo_onehot, 8'h01 << tab[i].passo);
      chk($sformatf("vec%0d_erro", i), erro, tab[i].erro);
      chk($sformatf("vec%0d_estado", i), estado, tab[i].estado);
      chk($sformatf("vec%0d_novo_passo", i), np_cnt, tab[i].np);
      chk($sformatf("vec%0d_ciclo", i), cc_cnt, tab[i].cc);
      if (tab[i].lat != 0) chk($sformatf("vec%0d_latency", i), np_at, tab[i].lat);
    end
    // abort mid-filter, then first value after release is free
    hold(3'd1, 13);
    async_botao("botao_mid_filter");
    hold(3'd5, 40);
    chk("after_rst_passo", passo, 5);
    chk("after_rst_estado", estado, 1);
    chk("after_rst_erro", erro, 0);
    hold(3'd2, 40);
    chk("erro_before_botao", erro, 1);
    async_botao("botao_in_erro");
    hold(3'd2, 40);
    chk("erro_cleared_passo", passo, 2);
    chk("erro_cleared_erro", erro, 0);
    // fast toggling never settles long enough
    raw = 3'd3;
    np_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      raw = (i % 2) ? 3'd4 : 3'd3;
      for (int j = 1; j <= 4; j++) tick(j);
    end
    chk("toggle_no_pulse", np_cnt, 0);
    chk("toggle_passo", passo, 2);
    for (int i = 0; i < 80; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 2) != 0) ? 3'(m_passo + 1) : 3'($urandom_range(0, 7));
      hold(c, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 30));
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
